// File: rtl/sys_mem_resp_pkg.sv
// Shared types and constants for the sys_mem_resp word memory responder:
// burst-tracking FSM encoding and the saturating burst-length counter.
package sys_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } burstState_t;

  localparam int                BURST_W   = 5;
  localparam logic [BURST_W-1:0] BURST_MAX = 5'd31;

  function automatic logic [BURST_W-1:0] satInc(input logic [BURST_W-1:0] v);
    return (v == BURST_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sys_mem_resp_rd_pipe.sv
// Read-latency pipeline: RD_LAT-deep valid/data shift. Each stage's data only
// advances with a valid beat, so the last stage holds the most recent response.
module rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic        reqValid,
  input  logic [15:0] reqData,
  output logic        rspValid,
  output logic [15:0] rspData
);

  logic [RD_LAT-1:0] stageValid;
  logic [15:0]       stageData [RD_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value, giving a true shift register.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      stageValid <= '0;
      for (int i = 0; i < RD_LAT; i++) stageData[i] <= '0;
    end else begin
      stageValid[0] <= reqValid;
      if (reqValid) stageData[0] <= reqData;
      for (int i = 1; i < RD_LAT; i++) begin
        stageValid[i] <= stageValid[i-1];
        if (stageValid[i-1]) stageData[i] <= stageData[i-1];
      end
    end
  end

  assign rspValid = stageValid[RD_LAT-1];
  assign rspData  = stageData[RD_LAT-1];

endmodule

// File: rtl/sys_mem_resp.sv
// Word-addressed 16-bit memory responder: preload port, pipelined reads,
// sticky error flag and a same-kind burst-length tracker.
module sys_mem_resp
  import sys_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic               Clk1,
  input  logic               Reset,
  input  logic [15:0]        Addr,
  input  logic               RD,
  input  logic               WR,
  input  logic [15:0]        DataIn,
  output logic [15:0]        DataOut,
  output logic               Valid,
  output logic               Err,
  output logic [BURST_W-1:0] BurstLen,
  input  logic               LdEn,
  input  logic [15:0]        LdAddr,
  input  logic [15:0]        LdData
);

  logic [15:0] mem [2**ADDR_W];

  logic              addrInRange, ldInRange;
  logic              readAcc, writeAcc, doLoad, errEvent;
  logic [15:0]       readData;
  burstState_t       state, nextState;
  logic [BURST_W-1:0] burstCnt, burstNext;

  // Shift form keeps the range test legal when ADDR_W covers all 16 bits.
  assign addrInRange = (Addr >> ADDR_W) == 16'd0;
  assign ldInRange   = (LdAddr >> ADDR_W) == 16'd0;

  assign readAcc  = RD & ~WR & ~LdEn;
  assign writeAcc = WR & ~LdEn & addrInRange;
  assign doLoad   = LdEn & ldInRange;
  assign errEvent = (RD & WR & ~LdEn)
                  | (WR & ~LdEn & ~addrInRange)
                  | (readAcc & ~addrInRange)
                  | (LdEn & (RD | WR))
                  | (LdEn & ~ldInRange);

  assign readData = addrInRange ? mem[Addr[ADDR_W-1:0]] : 16'h0000;

  // NOTE: the memory array has no reset branch; contents survive Reset and the
  // array maps onto plain RAM. Reset only blocks writes on its own edge.
  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      if (doLoad)        mem[LdAddr[ADDR_W-1:0]] <= LdData;
      else if (writeAcc) mem[Addr[ADDR_W-1:0]]   <= DataIn;
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset)         Err <= 1'b0;
    else if (errEvent) Err <= 1'b1;
  end

  rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .reqValid (readAcc),
    .reqData  (readData),
    .rspValid (Valid),
    .rspData  (DataOut)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state    <= IDLE;
      burstCnt <= '0;
    end else begin
      state    <= nextState;
      burstCnt <= burstNext;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nextState = IDLE;
    if (readAcc)       nextState = RBURST;
    else if (writeAcc) nextState = WBURST;
  end

  always_comb begin
    burstNext = '0;
    if (nextState != IDLE)
      burstNext = (nextState == state) ? satInc(burstCnt) : BURST_W'(1);
  end

  assign BurstLen = burstCnt;

endmodule

// File: tb/tb_sys_mem_resp.sv
// Bench for sys_mem_resp: RD_LAT=1 and RD_LAT=3 instances share stimulus and
// are compared each cycle against a transaction-level model plus literal pins.
module tb_sys_mem_resp;
  import sys_mem_resp_pkg::*;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b1, RD = 1'b0, WR = 1'b0, LdEn = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0, LdAddr = '0, LdData = '0;

  logic [15:0]        dataOut1, dataOut3;
  logic               valid1, valid3, err1, err3;
  logic [BURST_W-1:0] burstLen1, burstLen3;

  sys_mem_resp #(.ADDR_W(10), .RD_LAT(1)) dut1 (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(dataOut1), .Valid(valid1), .Err(err1), .BurstLen(burstLen1),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

  sys_mem_resp #(.ADDR_W(10), .RD_LAT(3)) dut3 (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(dataOut3), .Valid(valid3), .Err(err3), .BurstLen(burstLen3),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData));

  always #5 Clk1 = ~Clk1;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, per-latency response queues, burst run length.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] mMem [1024];
  rsp_t        q1[$], q3[$];
  int          edgeN = 0, lastKind = 0, eBurst = 0;
  bit          modelLive = 0, eErr = 0, eV1 = 0, eV3 = 0;
  logic [15:0] eD1 = '0, eD3 = '0;

  always @(posedge Clk1) begin
    bit          inR, ldR;
    int          kind;
    logic [15:0] rd;
    rsp_t        t;
    edgeN++;
    if (Reset) begin
      q1.delete(); q3.delete();
      eV1 = 0; eV3 = 0; eD1 = '0; eD3 = '0; eErr = 0; eBurst = 0; lastKind = 0;
      modelLive = 1;
    end else begin
      inR  = Addr < 16'd1024;
      ldR  = LdAddr < 16'd1024;
      kind = 0;
      if (LdEn) begin
        if (RD || WR || !ldR) eErr = 1;
        if (ldR) mMem[LdAddr[9:0]] = LdData;
      end else if (WR) begin
        if (RD || !inR) eErr = 1;
        if (inR) begin mMem[Addr[9:0]] = DataIn; kind = 2; end
      end else if (RD) begin
        rd = inR ? mMem[Addr[9:0]] : 16'h0000;
        if (!inR) eErr = 1;
        q1.push_back('{edgeN, rd});
        q3.push_back('{edgeN + 2, rd});
        kind = 1;
      end
      if (kind == 0)             eBurst = 0;
      else if (kind == lastKind) eBurst = (eBurst < 31) ? eBurst + 1 : 31;
      else                       eBurst = 1;
      lastKind = kind;
      eV1 = 0;
      if (q1.size() > 0 && q1[0].due == edgeN) begin t = q1.pop_front(); eV1 = 1; eD1 = t.data; end
      eV3 = 0;
      if (q3.size() > 0 && q3[0].due == edgeN) begin t = q3.pop_front(); eV3 = 1; eD3 = t.data; end
    end
  end

  always @(negedge Clk1) begin
    if (modelLive) begin
      check("valid1",    {15'b0, valid1},     {15'b0, eV1});
      check("dataOut1",  dataOut1,            eD1);
      check("err1",      {15'b0, err1},       {15'b0, eErr});
      check("burstLen1", 16'(burstLen1),      16'(eBurst));
      check("valid3",    {15'b0, valid3},     {15'b0, eV3});
      check("dataOut3",  dataOut3,            eD3);
      check("err3",      {15'b0, err3},       {15'b0, eErr});
      check("burstLen3", 16'(burstLen3),      16'(eBurst));
    end
  end

  task automatic drive(input logic rst, rd, wr, ld, input logic [15:0] a, d);
    @(negedge Clk1);
    Reset = rst; RD = rd; WR = wr; LdEn = ld;
    Addr = a; DataIn = d; LdAddr = a; LdData = d;
  endtask

  task automatic idle();                               drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0); endtask
  task automatic rstCyc();                             drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0); endtask
  task automatic load(input logic [15:0] a, d);        drive(1'b0, 1'b0, 1'b0, 1'b1, a, d);         endtask
  task automatic rdReq(input logic [15:0] a);          drive(1'b0, 1'b1, 1'b0, 1'b0, a, 16'h0);     endtask
  task automatic wrReq(input logic [15:0] a, d);       drive(1'b0, 1'b0, 1'b1, 1'b0, a, d);         endtask

  initial begin
    rstCyc(); rstCyc(); idle();
    check("rst_valid", {15'b0, valid1}, 16'h0);
    check("rst_data",  dataOut1, 16'h0);
    check("rst_err",   {15'b0, err1}, 16'h0);
    check("rst_burst", 16'(burstLen1), 16'h0);

    load(16'h0010, 16'hBEEF);
    load(16'h0000, 16'h0F0F);
    for (int i = 0; i < 16; i++) load(16'h0100 + 16'(i), 16'(i));

    rdReq(16'h0010); idle();
    check("pre_valid", {15'b0, valid1}, 16'h1);
    check("pre_data",  dataOut1, 16'hBEEF);
    check("pre_err",   {15'b0, err1}, 16'h0);
    check("pre_burst", 16'(burstLen1), 16'h1);

    for (int i = 0; i < 16; i++) begin
      rdReq(16'h0100 + 16'(i));
      if (i > 0) begin
        check("burst_rd_data", dataOut1, 16'(i - 1));
        check("burst_rd_len",  16'(burstLen1), 16'(i));
      end
    end
    idle();
    check("burst_rd_last", dataOut1, 16'd15);
    check("burst_rd_16",   16'(burstLen1), 16'd16);

    wrReq(16'h0020, 16'h1234); rdReq(16'h0020); idle();
    check("wr_rd_valid", {15'b0, valid1}, 16'h1);
    check("wr_rd_data",  dataOut1, 16'h1234);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h5555); idle();
    check("rdwr_valid", {15'b0, valid1}, 16'h0);
    check("rdwr_err",   {15'b0, err1}, 16'h1);
    rdReq(16'h0030); idle();
    check("rdwr_store", dataOut1, 16'h5555);

    rstCyc(); idle();
    check("err_cleared", {15'b0, err1}, 16'h0);
    rdReq(16'h0400); idle();
    check("oor_rd_valid", {15'b0, valid1}, 16'h1);
    check("oor_rd_data",  dataOut1, 16'h0000);
    check("oor_rd_err",   {15'b0, err1}, 16'h1);
    wrReq(16'h0400, 16'h7777); rdReq(16'h0000); idle();
    check("oor_wr_nostore", dataOut1, 16'h0F0F);
    check("oor_wr_err",     {15'b0, err1}, 16'h1);

    rstCyc(); idle();
    rdReq(16'h0010); rdReq(16'h0100); rstCyc(); idle(); idle(); idle();
    check("inflight_valid3", {15'b0, valid3}, 16'h0);
    check("inflight_data3",  dataOut3, 16'h0);
    check("inflight_err3",   {15'b0, err3}, 16'h0);
    check("inflight_burst3", 16'(burstLen3), 16'h0);
    rdReq(16'h0010); idle(); idle(); idle();
    check("lat3_valid", {15'b0, valid3}, 16'h1);
    check("lat3_data",  dataOut3, 16'hBEEF);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hAAAA); idle();
    check("ld_rd_valid", {15'b0, valid1}, 16'h0);
    check("ld_rd_err",   {15'b0, err1}, 16'h1);
    rdReq(16'h0040); idle();
    check("ld_rd_store", dataOut1, 16'hAAAA);

    rstCyc();
    for (int i = 0; i < 40; i++) begin
      wrReq(16'h0200 + 16'(i), 16'(i));
      if (i == 31) check("wr_burst_31", 16'(burstLen1), 16'd31);
    end
    idle();
    check("wr_burst_sat", 16'(burstLen1), 16'd31);
    idle();
    check("wr_burst_idle", 16'(burstLen1), 16'd0);
    rdReq(16'h0227); idle();
    check("wr_burst_data", dataOut1, 16'h0027);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sys_mem_resp.md
SYS_MEM_RESP -- requirements
Module: sys_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set implemented words = 2**ADDR_W (legal 4..16).
REQ-002 Parameter RD_LAT, default 1, SHALL set read latency in cycles (legal 1..4).
REQ-003 Clk1  input  1  sole clock; all state updates on posedge Clk1.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Addr  input  16  word address from processor.
REQ-006 RD  input  1  read request, sampled every cycle; may stay high across consecutive addresses.
REQ-007 WR  input  1  write request, sampled every cycle; may stay high across consecutive addresses.
REQ-008 DataIn  input  16  write data from processor.
REQ-009 DataOut  output  16  read data to processor.
REQ-010 Valid  output  1  DataOut carries a read response this cycle.
REQ-011 Err  output  1  sticky protocol/range error flag.
REQ-012 BurstLen  output  5  length of the current same-kind access run, saturating.
REQ-013 LdEn  input  1  bench/boot preload strobe.
REQ-014 LdAddr  input  16  preload address; LdData  input  16  preload data.

Function
REQ-015 Memory SHALL be a 2**ADDR_W x 16 array; an address is in range iff Addr[15:ADDR_W]==0.
REQ-016 Write: WR=1, RD=0, LdEn=0, in range at an edge SHALL store DataIn at Addr on that edge; each WR cycle is one independent write (bursts need no extra handshake).
REQ-017 Read: RD=1 at edge N SHALL capture Addr; DataOut=mem[Addr] and Valid=1 during the cycle after edge N+RD_LAT-1 (RD_LAT=1: visible the cycle after the request edge).
REQ-018 Reads SHALL be fully pipelined: one request accepted per cycle; responses in request order; no bubbles.
REQ-019 Read data SHALL be sampled at the request edge; an earlier-edge write to the same address SHALL be visible (write-then-read on consecutive edges returns new data).
REQ-020 With Valid=0, DataOut SHALL hold its last value.
REQ-021 RD=1 and WR=1 on the same edge: write performed, read dropped (no Valid), Err set.
REQ-022 Out-of-range write SHALL be dropped and set Err; out-of-range read SHALL return 16'h0000 with Valid=1 at normal latency and set Err.
REQ-023 LdEn=1 SHALL write LdData to LdAddr and ignore RD/WR that edge; concurrent RD or WR SHALL set Err; out-of-range LdAddr dropped, Err set.
REQ-024 Err SHALL stay 1 until Reset.
REQ-025 FSM states IDLE, RBURST, WBURST: IDLE->RBURST on accepted read; IDLE->WBURST on accepted write; RBURST<->WBURST on kind change; any->IDLE on a cycle with no accepted access (incl. LdEn cycle).
REQ-026 BurstLen SHALL be 1 on entry to RBURST/WBURST, +1 per further same-kind access, saturate at 31, be 0 in IDLE; a kind switch restarts at 1.

Reset
REQ-027 Reset SHALL force DataOut=0, Valid=0, Err=0, BurstLen=0, state IDLE, and clear all in-flight read slots (no responses emerge after Reset).
REQ-028 Memory contents SHALL NOT be cleared by Reset; Reset has priority over RD/WR/LdEn that edge.

Structure
REQ-029 FSM state encoding (2-bit IDLE/RBURST/WBURST) and BurstLen width/saturation constant SHALL live in the shared package.
REQ-030 Read latency pipeline (RD_LAT-deep valid/data shift) SHALL be one sub-module, rd_pipe; array, decode, FSM stay in sys_mem_resp.

Verification
REQ-031 Preload 0x0010=16'hBEEF via LdEn; RD at 0x0010 (RD_LAT=1) -> next cycle Valid=1, DataOut=BEEF, Err=0, BurstLen=1.
REQ-032 RD held 16 cycles, Addr 0x0100..0x010F preloaded with index -> 16 consecutive Valid responses 0..15 in order, BurstLen counts 1..16.
REQ-033 WR 0x0020=16'h1234 then RD 0x0020 next edge -> DataOut=1234; RD+WR same edge -> no Valid, Err=1, write present.
REQ-034 ADDR_W=10, RD at 0x0400 -> Valid=1, DataOut=0000, Err=1; WR 0x0400 -> no store, Err stays 1.
REQ-035 RD_LAT=3, issue 2 reads, assert Reset before first response -> Valid never rises, all outputs 0, memory contents preserved.
REQ-036 40 consecutive writes -> BurstLen saturates at 31; one idle cycle -> BurstLen=0, state IDLE.
